// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Round-robin arbiter sharing one 32-bit log barrel shifter
//               (SLL/SRL/SRA/ROR) between the ALU execute port (0) and the
//               multdiv normalisation port (1). Results leave through a
//               registered, tagged output with consumer backpressure.
//               Optional macro SHIFT_ARB_PIPE_EN inserts a stage-1 register
//               ahead of the shifter (latency 2, full throughput kept).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id
);

    localparam logic [1:0]       c_op_sll = 2'b00;
    localparam logic [1:0]       c_op_srl = 2'b01;
    localparam logic [1:0]       c_op_sra = 2'b10;
    localparam logic [1:0]       c_op_ror = 2'b11;
    localparam logic [WIDTH-1:0] c_ones   = {WIDTH{1'b1}};

    // Arbitration and handshake
    logic             r_last_grant;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_can_accept;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_xfer;

    // Payload of the granted requester
    logic [1:0]       w_in_op;
    logic [WIDTH-1:0] w_in_data;
    logic [SHW-1:0]   w_in_shamt;

    // Operands actually presented to the shifter
    logic [1:0]       w_sh_op;
    logic [WIDTH-1:0] w_sh_data;
    logic [SHW-1:0]   w_sh_shamt;

    // Shifter internals
    logic             w_is_left;
    logic             w_is_rot;
    logic             w_fill;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_result;

    // Output register load control
    logic             w_load;
    logic             w_load_id;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_id;

    // Reverse bit order; lets the left shift reuse the right-shift network.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Round-robin grant: a lone requester wins, a tie goes to the port that
    // did not win the last transfer. Only valids and history are consulted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req0_valid && (!req1_valid || r_last_grant)) begin
            w_gnt0 = 1'b1;
        end else if (req1_valid) begin
            w_gnt1 = 1'b1;
        end
    end

    assign w_xfer0    = w_gnt0 & w_can_accept;
    assign w_xfer1    = w_gnt1 & w_can_accept;
    assign w_xfer     = w_xfer0 | w_xfer1;
    assign req0_ready = w_xfer0;
    assign req1_ready = w_xfer1;

    assign w_in_op    = w_gnt1 ? req1_op    : req0_op;
    assign w_in_data  = w_gnt1 ? req1_data  : req0_data;
    assign w_in_shamt = w_gnt1 ? req1_shamt : req0_shamt;

    // Grant history: remember the winner of each transfer, hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_xfer1;
        end
    end

`ifdef SHIFT_ARB_PIPE_EN
    logic             r_s1_valid;
    logic [1:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_data;
    logic [SHW-1:0]   r_s1_shamt;
    logic             r_s1_id;
    logic             w_s1_adv;

    // Stage 1 moves forward when the output register is free or draining.
    assign w_s1_adv     = r_s1_valid & (~r_out_valid | out_ready);
    assign w_can_accept = ~r_s1_valid | w_s1_adv;

    // Stage-1 capture of the accepted operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_data  <= '0;
            r_s1_shamt <= '0;
            r_s1_id    <= 1'b0;
        end else if (w_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= w_in_op;
            r_s1_data  <= w_in_data;
            r_s1_shamt <= w_in_shamt;
            r_s1_id    <= w_xfer1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    assign w_sh_op    = r_s1_op;
    assign w_sh_data  = r_s1_data;
    assign w_sh_shamt = r_s1_shamt;
    assign w_load     = w_s1_adv;
    assign w_load_id  = r_s1_id;
`else
    assign w_can_accept = ~r_out_valid | out_ready;
    assign w_sh_op      = w_in_op;
    assign w_sh_data    = w_in_data;
    assign w_sh_shamt   = w_in_shamt;
    assign w_load       = w_xfer;
    assign w_load_id    = w_xfer1;
`endif

    assign w_is_left = (w_sh_op == c_op_sll);
    assign w_is_rot  = (w_sh_op == c_op_ror);
    // SRA fill comes from the original operand MSB, not from the stage input,
    // so every stage sees the same sign. SRL and SLL fill with zeros.
    assign w_fill    = (w_sh_op == c_op_sra) & w_sh_data[WIDTH-1];

    // Five-stage log right shifter (16/8/4/2/1); rotate re-inserts the bits
    // falling off bit 0, left shift runs on the bit-reversed operand.
    always_comb begin
        w_acc = w_is_left ? bit_rev(w_sh_data) : w_sh_data;
        for (int s = SHW - 1; s >= 0; s--) begin
            if (w_sh_shamt[s]) begin
                w_acc = (w_acc >> (1 << s)) |
                        (w_is_rot ? (w_acc << (WIDTH - (1 << s))) :
                         (w_fill  ? ~(c_ones >> (1 << s)) : '0));
            end
        end
    end

    assign w_result = w_is_left ? bit_rev(w_acc) : w_acc;

    // Output register: load a new result, otherwise drop valid once taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_id    <= w_load_id;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit barrel shifter between two requesters: port 0 (ALU execute) and port 1 (multdiv normalisation).
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- Operations: SLL, SRL, SRA, ROR.
- Result leaves through a registered output with a requester tag and consumer backpressure.
- Sits between the execute-stage issue logic and the writeback mux.

Parameters:
- WIDTH, 32, operand/result width; only 32 supported.
- SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- req0_data  input  32  operand.
- req0_shamt  input  5  shift amount.
- req1_valid  input  1  requester 1 has an operation.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_op  input  2  same encoding as req0_op.
- req1_data  input  32  operand.
- req1_shamt  input  5  shift amount.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  32  shifted result.
- out_id  output  1  requester that owns out_data.

Behaviour:
- Reset (reset_n low, takes effect immediately): out_valid=0, out_data=0, out_id=0, last_grant=1, all pipeline valids=0. reset_n asserted mid-operation drops in-flight results; no partial output.
- can_accept = !out_valid | out_ready (base build).
- Grant, combinational, at most one per cycle:
  - only reqN_valid -> grant N;
  - both valid -> grant the port != last_grant;
  - neither -> none.
- reqN_ready = grant==N & can_accept. reqN_ready never depends on that port's own operand/op fields.
- Handshake:
  - transfer occurs when reqN_valid & reqN_ready;
  - on transfer, last_grant <= N;
  - when no transfer occurs, last_grant holds.
- Requester rules: holds valid and payload stable until ready. The arbiter does not reorder.
- Shift semantics:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with data[31], copied from the original operand at every stage of the log shifter.
  - ROR: bits shifted out of bit 0 re-enter at bit 31.
  - shamt=0 passes data unchanged for every op.
  - shamt=31 limits: SRA gives all sign bits except bit 0 = data[31]; SLL gives data[0]<<31.
- Datapath: 5-stage log shifter (16/8/4/2/1), muxed by op. Left shift is done by bit-reversing, right-shifting, and reversing back.
- Output register:
  - on transfer: out_valid<=1, out_data<=result, out_id<=N;
  - else if out_ready: out_valid<=0;
  - out_data/out_id hold while out_valid & !out_ready.
- Latency 1 cycle from transfer edge to out_valid. Throughput 1 op/cycle under continuous out_ready.
- Simultaneous drain and accept in one cycle is legal. The register is overwritten with the new result and out_valid stays 1.
- Fairness: with both requesters always valid and out_ready=1, grants alternate 0,1,0,1…
- Starvation: none; a waiting port wins at most one grant later.

Optional Feature:
- Macro: SHIFT_ARB_PIPE_EN.
- Defined: a stage-1 register captures op/data/shamt/id at transfer, and stage 2 is the output register.
  - Latency 2 cycles.
  - Stage 1 advances when stage 2 is empty or out_ready.
  - can_accept = !s1_valid | stage-1 advancing.
  - Full throughput is kept; no bubble under continuous out_ready.
- Undefined: single-stage behaviour above; no stage-1 flops synthesised.

Test Plan:
- Reset then idle: reset_n=0 mid-run -> out_valid=0 immediately, out_data=0; after release, req0 and req1 valid together -> req0 granted first.
- SRA sign fill: req0 op=10 data=0x80000000 shamt=4 -> out_data=0xF8000000, out_id=0, one cycle after transfer (two cycles with SHIFT_ARB_PIPE_EN).
- All ops, data=0x12345678 shamt=8:
  - SLL -> 0x34567800;
  - SRL -> 0x00123456;
  - SRA -> 0x00123456;
  - ROR -> 0x78123456;
  - shamt=0 -> 0x12345678 for all ops.
- Round-robin: both valid for 6 cycles, out_ready=1 -> out_id sequence 0,1,0,1,0,1; no gaps.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, both reqN_ready=0. out_ready=1 with both requesters valid -> drain and new accept in the same cycle, out_valid stays 1.
- Single requester: only req1 valid for 4 cycles -> req1 granted every cycle, last_grant=1 throughout.
